// File: rtl/counter_pkg.sv
// Shared encodings for the counter sequencer: FSM states, direction codes and
// the configuration that applies after reset.
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Reset config is a plain full-range up counter. mod=0 encodes 2^WIDTH and
  // start=0, so both are written as '0 at the use site.
  localparam logic RST_CFG_DIR    = DIR_UP;
  localparam logic RST_CFG_RELOAD = 1'b1;

endpackage

// File: rtl/mod_n_counter.sv
// Mod-M up/down counter datapath. mod carries the effective modulus M
// (1..2^WIDTH) one bit wider than q, so 2^WIDTH is representable.
module mod_n_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  input  logic [WIDTH:0]   mod,
  output logic [WIDTH-1:0] q,
  output logic             at_term
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH:0]   w_q_ext;
  logic [WIDTH:0]   w_last;
  logic [WIDTH-1:0] w_next;

  assign w_q_ext = {1'b0, r_q};
  assign w_last  = mod - (WIDTH+1)'(1);
  assign q       = r_q;

  always_comb begin
    at_term = 1'b0;
    w_next  = r_q;
    if (dir == DIR_UP) begin
      at_term = (w_q_ext == w_last);
      w_next  = at_term ? '0 : r_q + 1'b1;
    end else begin
      at_term = (r_q == '0);
      w_next  = at_term ? w_last[WIDTH-1:0] : r_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_q <= '0;
    else if (load) r_q <= load_val;
    else if (en)   r_q <= w_next;
  end

endmodule

// File: rtl/counter_sequencer.sv
// Sequencer around mod_n_counter: config handshake, start/stop/clear commands,
// terminal-count and one-shot done reporting. dbg_state mirrors the FSM.
// Handshake: a config offer transfers on an edge where cfg_valid && cfg_ready;
// cfg_ready is high only in IDLE, so the source must hold its offer until then.
module counter_sequencer
  import counter_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_mod,
  input  logic             cfg_dir,
  input  logic             cfg_reload,
  input  logic [WIDTH-1:0] cfg_start,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc,
  output logic             done,
  output logic [1:0]       dbg_state
);

  state_t           r_state;
  logic [WIDTH-1:0] r_mod;
  logic             r_dir;
  logic             r_reload;
  logic [WIDTH-1:0] r_start_val;

  logic             w_cfg_hs;
  logic [WIDTH-1:0] w_sel_mod;
  logic             w_sel_dir;
  logic [WIDTH-1:0] w_sel_start;
  logic [WIDTH:0]   w_sel_m;
  logic [WIDTH:0]   w_run_m;
  logic [WIDTH-1:0] w_clamp;
  logic             w_start_cmd;
  logic             w_load;
  logic [WIDTH-1:0] w_load_val;
  logic             w_en;
  logic             w_at_term;

  function automatic logic [WIDTH:0] eff_mod(input logic [WIDTH-1:0] m);
    return (m == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, m};
  endfunction

  // A start in the same cycle as the handshake must see the incoming config.
  assign w_cfg_hs    = cfg_valid && (r_state == ST_IDLE);
  assign w_sel_mod   = w_cfg_hs ? cfg_mod   : r_mod;
  assign w_sel_dir   = w_cfg_hs ? cfg_dir   : r_dir;
  assign w_sel_start = w_cfg_hs ? cfg_start : r_start_val;
  assign w_sel_m     = eff_mod(w_sel_mod);
  assign w_run_m     = eff_mod(r_mod);

  always_comb begin
    w_clamp = w_sel_start;
    if ({1'b0, w_sel_start} >= w_sel_m) begin
      if (w_sel_dir == DIR_UP) w_clamp = '0;
      else                     w_clamp = w_sel_m[WIDTH-1:0] - 1'b1;
    end
  end

  assign w_start_cmd = (r_state == ST_IDLE) && start && !clear;
  assign w_load      = clear || w_start_cmd;
  assign w_load_val  = clear ? '0 : w_clamp;
  // One-shot completion holds q at the terminal value instead of wrapping.
  assign w_en        = (r_state == ST_RUN) && !clear && !stop &&
                       !(!r_reload && w_at_term);

  mod_n_counter #(.WIDTH(WIDTH)) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_load_val),
    .en       (w_en),
    .dir      (r_dir),
    .mod      (w_run_m),
    .q        (q),
    .at_term  (w_at_term)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_mod       <= '0;
      r_dir       <= RST_CFG_DIR;
      r_reload    <= RST_CFG_RELOAD;
      r_start_val <= '0;
    end else begin
      if (w_cfg_hs) begin
        r_mod       <= cfg_mod;
        r_dir       <= cfg_dir;
        r_reload    <= cfg_reload;
        r_start_val <= cfg_start;
      end
      case (r_state)
        ST_IDLE: if (w_start_cmd) r_state <= ST_RUN;
        ST_RUN: begin
          if (clear)                        r_state <= ST_IDLE;
          else if (stop)                    r_state <= ST_HOLD;
          else if (!r_reload && w_at_term)  r_state <= ST_DONE;
        end
        ST_HOLD: begin
          if (clear)             r_state <= ST_IDLE;
          else if (!stop && start) r_state <= ST_RUN;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cfg_ready = (r_state == ST_IDLE);
  assign busy      = (r_state == ST_RUN) || (r_state == ST_HOLD);
  assign tc        = (r_state == ST_RUN) && w_at_term;
  assign done      = (r_state == ST_DONE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer. Observations are packed as
// {q, tc, busy, done, cfg_ready, state} and compared against hand-computed values.
module tb_counter_sequencer;

  logic       clk;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [2:0] cfg_mod;
  logic       cfg_dir;
  logic       cfg_reload;
  logic [2:0] cfg_start;
  logic       start;
  logic       stop;
  logic       clear;
  logic [2:0] q;
  logic       busy;
  logic       tc;
  logic       done;
  logic [1:0] dbg_state;

  logic [8:0] obs;
  logic [8:0] exp;
  int         checks;
  int         errors;

  assign obs = {q, tc, busy, done, cfg_ready, dbg_state};

  counter_sequencer #(.WIDTH(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_mod    (cfg_mod),
    .cfg_dir    (cfg_dir),
    .cfg_reload (cfg_reload),
    .cfg_start  (cfg_start),
    .start      (start),
    .stop       (stop),
    .clear      (clear),
    .q          (q),
    .busy       (busy),
    .tc         (tc),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, bench did not finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic offer_cfg(input logic [2:0] m, input logic d, input logic rl,
                           input logic [2:0] s, input logic with_start);
    cfg_valid  = 1'b1;
    cfg_mod    = m;
    cfg_dir    = d;
    cfg_reload = rl;
    cfg_start  = s;
    start      = with_start;
    tick();
    cfg_valid  = 1'b0;
    start      = 1'b0;
  endtask

  task automatic do_clear;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // scenarios
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    exp = {3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset: got {q,tc,busy,done,rdy,st}=%b expected %b", obs, exp);
    end
  endtask

  task automatic test_free_run;
    int v;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      v = i % 8;
      exp = {3'(v), (v == 7), 1'b1, 1'b0, 1'b0, 2'd1};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL free_run[%0d]: got %b expected %b", i, obs, exp);
      end
      tick();
    end
    do_clear();
    exp = {3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL free_run_clear: got %b expected %b", obs, exp);
    end
  endtask

  // start is held high throughout: it must be ignored in RUN and DONE
  task automatic test_oneshot_down;
    offer_cfg(3'd5, 1'b1, 1'b0, 3'd3, 1'b1);
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = {3'(3 - i), (i == 3), 1'b1, 1'b0, 1'b0, 2'd1};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL oneshot_down[%0d]: got %b expected %b", i, obs, exp);
      end
      tick();
    end
    exp = {3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL oneshot_done: got %b expected %b", obs, exp);
    end
    tick();
    start = 1'b0;
    exp = {3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL oneshot_idle: got %b expected %b", obs, exp);
    end
  endtask

  task automatic test_hold;
    int v;
    offer_cfg(3'd6, 1'b0, 1'b1, 3'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      exp = {3'(i), 1'b0, 1'b1, 1'b0, 1'b0, 2'd1};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL hold_pre[%0d]: got %b expected %b", i, obs, exp);
      end
      if (i < 4) tick();
    end
    stop = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      exp = {3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL hold[%0d]: got %b expected %b", k, obs, exp);
      end
    end
    stop  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp = {3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL hold_resume: got %b expected %b", obs, exp);
    end
    for (int j = 0; j < 3; j++) begin
      tick();
      v = (5 + j) % 6;
      exp = {3'(v), (v == 5), 1'b1, 1'b0, 1'b0, 2'd1};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL hold_post[%0d]: got %b expected %b", j, obs, exp);
      end
    end
    do_clear();
  endtask

  task automatic test_cfg_block_clear;
    offer_cfg(3'd0, 1'b0, 1'b1, 3'd2, 1'b1);
    repeat (2) tick();
    cfg_valid  = 1'b1;
    cfg_mod    = 3'd3;
    cfg_dir    = 1'b0;
    cfg_reload = 1'b1;
    cfg_start  = 3'd0;
    exp = {3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL cfg_blocked: got %b expected %b", obs, exp);
    end
    for (int j = 5; j < 8; j++) begin
      tick();
      exp = {3'(j), (j == 7), 1'b1, 1'b0, 1'b0, 2'd1};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL cfg_unchanged[%0d]: got %b expected %b", j, obs, exp);
      end
    end
    do_clear();
    exp = {3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL cfg_clear: got %b expected %b", obs, exp);
    end
    tick();
    cfg_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 5; j++) begin
      exp = {3'(j % 3), ((j % 3) == 2), 1'b1, 1'b0, 1'b0, 2'd1};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL cfg_accepted[%0d]: got %b expected %b", j, obs, exp);
      end
      tick();
    end
    do_clear();
  endtask

  task automatic test_clamp;
    offer_cfg(3'd5, 1'b0, 1'b1, 3'd6, 1'b1);
    exp = {3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL clamp_up: got %b expected %b", obs, exp);
    end
    do_clear();
    offer_cfg(3'd5, 1'b1, 1'b1, 3'd6, 1'b1);
    exp = {3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL clamp_down: got %b expected %b", obs, exp);
    end
    tick();
    exp = {3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL clamp_down_step: got %b expected %b", obs, exp);
    end
    do_clear();
    offer_cfg(3'd5, 1'b0, 1'b1, 3'd5, 1'b1);
    exp = {3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL clamp_eq_mod: got %b expected %b", obs, exp);
    end
    do_clear();
    offer_cfg(3'd5, 1'b0, 1'b1, 3'd4, 1'b1);
    exp = {3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL clamp_below_mod: got %b expected %b", obs, exp);
    end
    do_clear();
  endtask

  task automatic test_mod_one;
    offer_cfg(3'd1, 1'b0, 1'b0, 3'd0, 1'b1);
    exp = {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL mod1_run: got %b expected %b", obs, exp);
    end
    tick();
    exp = {3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL mod1_done: got %b expected %b", obs, exp);
    end
    tick();
    offer_cfg(3'd1, 1'b0, 1'b1, 3'd0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      exp = {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL mod1_reload[%0d]: got %b expected %b", k, obs, exp);
      end
      tick();
    end
    do_clear();
  endtask

  task automatic test_async_reset;
    offer_cfg(3'd7, 1'b0, 1'b1, 3'd3, 1'b1);
    repeat (2) tick();
    exp = {3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL areset_pre: got %b expected %b", obs, exp);
    end
    #2;
    rst = 1'b1;
    #1;
    exp = {3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL areset_immediate: got %b expected %b", obs, exp);
    end
    tick();
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    exp = {3'd7, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL areset_cfg_default: got %b expected %b", obs, exp);
    end
    do_clear();
  endtask

  task automatic test_stop_start_same_cycle;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    stop  = 1'b1;
    start = 1'b1;
    tick();
    stop  = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp = {3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL stop_start[%0d]: got %b expected %b", k, obs, exp);
      end
      tick();
    end
    do_clear();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    cfg_valid  = 1'b0;
    cfg_mod    = 3'd0;
    cfg_dir    = 1'b0;
    cfg_reload = 1'b0;
    cfg_start  = 3'd0;
    start      = 1'b0;
    stop       = 1'b0;
    clear      = 1'b0;
    test_reset();
    test_free_run();
    test_oneshot_down();
    test_hold();
    test_cfg_block_clear();
    test_clamp();
    test_mod_one();
    test_async_reset();
    test_stop_start_same_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Controller that configures, starts, pauses and terminates a mod-N up/down counter datapath.
- Replaces free-running hard-wired counters with one block that takes a config handshake, a start/stop/clear command interface, and reports terminal count and done.
- Sits between a control FSM or CPU register interface and any logic that consumes count values or wrap events.

Parameters:
- WIDTH, 3, counter width in bits. The max modulus is 2^WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- cfg_valid  input  1  config offer. Accepted on a cycle where cfg_valid and cfg_ready are both 1.
- cfg_ready  output  1  1 only in IDLE.
- cfg_mod  input  WIDTH  modulus. 0 encodes 2^WIDTH; 1 keeps q at 0.
- cfg_dir  input  1  0 = up, 1 = down.
- cfg_reload  input  1  1 = auto-reload (wrap), 0 = one-shot.
- cfg_start  input  WIDTH  initial count.
- start  input  1  start or resume command.
- stop  input  1  pause command.
- clear  input  1  synchronous abort to IDLE.
- q  output  WIDTH  current count.
- busy  output  1  1 in RUN or HOLD.
- tc  output  1  1 while in RUN and q equals the terminal value.
- done  output  1  one-cycle pulse on one-shot completion.

Behaviour:
- Reset (async): state IDLE; q=0, tc=0, done=0, busy=0, cfg_ready=1. Config registers reset to mod=0 (2^WIDTH), dir=up, reload=1, start=0. Start from reset therefore gives a plain mod-2^WIDTH up counter.
- Effective modulus M = (cfg_mod==0) ? 2^WIDTH : cfg_mod. Use WIDTH+1-bit internal arithmetic.
- Terminal value T: M-1 for up, 0 for down.
- States: IDLE, RUN, HOLD, DONE.
- Command priority every cycle: clear > stop > start.
- IDLE:
  - A config handshake captures all cfg_* fields at that edge.
  - start with the config handshake in the same cycle uses the new config.
  - start loads q with the start value at the edge and moves to RUN. If the start value >= M, load 0 for up or M-1 for down.
  - stop is ignored in IDLE.
- RUN:
  - Each edge, q steps ±1 modulo M. Up: T→0. Down: 0→M-1.
  - First step happens on the edge after the load edge.
  - Auto-reload: wrap and stay in RUN indefinitely.
  - One-shot: on the edge where q==T, go to DONE with q held at T.
  - stop: go to HOLD, q frozen at its current value. The step on that edge is suppressed.
  - start while already in RUN is ignored.
- HOLD: q frozen and tc=0. start resumes RUN, and counting continues on the following edge. Config handshake is blocked.
- DONE: done=1 for exactly one cycle. Next edge goes to IDLE with q held at T. start during DONE is ignored.
- clear, any state: next edge goes to IDLE with q=0. Captured config is kept.
- M=1: q stays 0 and tc=1 continuously in RUN. One-shot finishes after 1 cycle in RUN.
- cfg_valid outside IDLE: cfg_ready=0. The offer must be held by the source until IDLE.
- rst mid-operation: immediate return to reset values. No done pulse.

Decomposition:
- Shared package (counter_pkg): state encoding (IDLE=0, RUN=1, HOLD=2, DONE=3), reset config constants, direction encoding localparams.
- One sub-module, mod_n_counter. Inputs: clk, rst, load, load_val, en, dir, mod. Outputs: q, at_term.
- The sequencer holds the FSM, config registers and start-value clamp. It drives load and en.

Test Plan:
1. After rst, pulse start with no config → q=0,1,…,7,0,1… with tc=1 exactly when q=7; busy=1, done never asserts.
2. Config mod=5, dir=down, reload=0, start=3, then start → q=3,2,1,0. tc=1 on the q=0 cycle, then done pulses one cycle, then IDLE with q=0 and cfg_ready=1.
3. Up, mod=6, auto-reload; stop at q=4 for 3 cycles, then start → q holds 4 through HOLD, then 5,0,1. tc=0 during HOLD.
4. In RUN, drive cfg_valid with mod=3 → cfg_ready=0, config unchanged. Assert clear → IDLE, q=0. The pending offer is accepted on the next cycle.
5. Config start=6 with mod=5, up, then start → q loads 0. Same config with dir=down → q loads 4.
6. Assert rst asynchronously mid-RUN at q=5 → q=0, state IDLE, tc=0, done=0 immediately, before the next clock edge. Start stop and start in the same cycle while in RUN → HOLD.
